// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit scheduler: FSM state encoding and
// sample-source select codes used by the fetch arbiter.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } i2s_state_t;

  typedef logic [1:0] src_sel_t;

  localparam src_sel_t SRC_S0   = 2'd0;
  localparam src_sel_t SRC_S1   = 2'd1;
  localparam src_sel_t SRC_NONE = 2'd2;

  localparam int UNDERRUN_CNT_W = 16;

  // Fixed priority: the primary source always wins when it has a sample.
  function automatic src_sel_t pick_source(input logic s0_valid, input logic s1_valid);
    src_sel_t sel;
    sel = SRC_NONE;
    if (s0_valid) begin
      sel = SRC_S0;
    end else if (s1_valid) begin
      sel = SRC_S1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock and word-select generator: clk divider, sck, bit counter and ws,
// plus single-cycle fall / fetch / frame-end strobes for the scheduler.
module i2s_sck_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic sck_o,
  output logic ws_o,
  output logic fall_o,
  output logic fetch_o,
  output logic frame_end_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             half_tick;
  logic             wrap;

  // Strobes are decoded from the current count so they coincide with the
  // clk edge that actually moves sck/ws.
  assign half_tick   = active && (div_cnt == DIV_LAST);
  assign fall_o      = half_tick && sck_o;
  assign wrap        = fall_o && (bit_cnt == BIT_LAST);
  assign fetch_o     = wrap && !ws_o;
  assign frame_end_o = wrap && ws_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sck_o   <= 1'b0;
      ws_o    <= 1'b0;
    end else if (!active) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sck_o   <= 1'b0;
      ws_o    <= 1'b0;
    end else begin
      div_cnt <= half_tick ? '0 : div_cnt + 1'b1;
      if (half_tick) begin
        sck_o <= ~sck_o;
      end
      if (fall_o) begin
        bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;
      end
      if (wrap) begin
        ws_o <= ~ws_o;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_sched.sv
// I2S transmit scheduler: run/drain FSM, two-source sample arbitration and channel
// word registers. Define I2S_TX_SCHED_UNDERRUN_CNT_EN to add a saturating underrun counter.
module i2s_tx_sched
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  output logic                    sck_o,
  output logic                    ws_o,
  output logic [DATA_WIDTH-1:0]   ldata_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic                    s0_valid_i,
  output logic                    s0_ready_o,
  input  logic [2*DATA_WIDTH-1:0] s0_data_i,
  input  logic                    s1_valid_i,
  output logic                    s1_ready_o,
  input  logic [2*DATA_WIDTH-1:0] s1_data_i,
  output logic                    underrun_o,
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
  output logic                    busy_o,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
`else
  output logic                    busy_o
`endif
);

  localparam int PAIR_W = 2 * DATA_WIDTH;

  i2s_state_t            state_q;
  i2s_state_t            state_d;
  logic                  active;
  logic                  fall_stb;
  logic                  fetch_stb;
  logic                  fend_stb;
  logic                  fetch_evt;
  logic                  fend_evt;
  src_sel_t              src_sel;
  logic [PAIR_W-1:0]     acc_pair;
  logic [DATA_WIDTH-1:0] pend_q;

  assign active = (state_q != IDLE);
  assign busy_o = active;

  i2s_sck_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .active     (active),
    .sck_o      (sck_o),
    .ws_o       (ws_o),
    .fall_o     (fall_stb),
    .fetch_o    (fetch_stb),
    .frame_end_o(fend_stb)
  );

  // ws only ever moves on an sck fall; qualifying keeps that relationship explicit.
  assign fetch_evt = fall_stb && fetch_stb;
  assign fend_evt  = fall_stb && fend_stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Returning to IDLE only at a frame end keeps every started frame whole.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (en_i) begin
          state_d = RUN;
        end else if (fend_evt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_sel    = pick_source(s0_valid_i, s1_valid_i);
    acc_pair   = '0;
    s0_ready_o = 1'b0;
    s1_ready_o = 1'b0;
    underrun_o = 1'b0;
    if (fetch_evt) begin
      case (src_sel)
        SRC_S0: begin
          s0_ready_o = 1'b1;
          acc_pair   = s0_data_i;
        end
        SRC_S1: begin
          s1_ready_o = 1'b1;
          acc_pair   = s1_data_i;
        end
        default: underrun_o = 1'b1;
      endcase
    end
  end

  // Left word goes out at the ws rise; the right word waits in pend_q until ws falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldata_o <= '0;
      rdata_o <= '0;
      pend_q  <= '0;
    end else begin
      if (fetch_evt) begin
        ldata_o <= acc_pair[PAIR_W-1:DATA_WIDTH];
        pend_q  <= acc_pair[DATA_WIDTH-1:0];
      end
      if (fend_evt) begin
        rdata_o <= pend_q;
      end
    end
  end

`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt_o <= '0;
    end else if (underrun_o && (underrun_cnt_o != {UNDERRUN_CNT_W{1'b1}})) begin
      underrun_cnt_o <= underrun_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Self-checking bench for i2s_tx_sched: timing, arbitration, drain, reset and a
// randomized run against an arithmetic model of sck/ws position.
module tb_i2s_tx_sched;

  localparam int DW = 16;
  localparam int CD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en_i;
  logic            sck_o;
  logic            ws_o;
  logic [DW-1:0]   ldata_o;
  logic [DW-1:0]   rdata_o;
  logic            s0_valid_i;
  logic            s0_ready_o;
  logic [2*DW-1:0] s0_data_i;
  logic            s1_valid_i;
  logic            s1_ready_o;
  logic [2*DW-1:0] s1_data_i;
  logic            underrun_o;
  logic            busy_o;
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
  logic [15:0]     underrun_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_l;
  logic [DW-1:0] exp_r;
  logic [DW-1:0] exp_pend;

  always #5 clk = ~clk;

  i2s_tx_sched #(
    .DATA_WIDTH(DW),
    .CLK_DIV   (CD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .sck_o     (sck_o),
    .ws_o      (ws_o),
    .ldata_o   (ldata_o),
    .rdata_o   (rdata_o),
    .s0_valid_i(s0_valid_i),
    .s0_ready_o(s0_ready_o),
    .s0_data_i (s0_data_i),
    .s1_valid_i(s1_valid_i),
    .s1_ready_o(s1_ready_o),
    .s1_data_i (s1_data_i),
    .underrun_o(underrun_o),
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
    .busy_o    (busy_o),
    .underrun_cnt_o(underrun_cnt_o)
`else
    .busy_o    (busy_o)
`endif
  );

  // Reference: k = clk edges since RUN was entered. Half-periods are k/CD,
  // completed sck falls are half-periods/2, ws flips every DW falls.
  function automatic logic m_sck(input int k);
    return ((k / CD) % 2) == 1;
  endfunction

  function automatic logic m_ws(input int k);
    return (((k / CD) / 2 / DW) % 2) == 1;
  endfunction

  function automatic logic m_fetch(input int k);
    return m_ws(k + 1) && !m_ws(k);
  endfunction

  function automatic logic m_fend(input int k);
    return !m_ws(k + 1) && m_ws(k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    en_i       = 1'b0;
    s0_valid_i = 1'b0;
    s1_valid_i = 1'b0;
    s0_data_i  = '0;
    s1_data_i  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_l    = '0;
    exp_r    = '0;
    exp_pend = '0;
  endtask

  // After this returns, the DUT has just latched RUN (k = 0).
  task automatic start_run();
    en_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    en_i       = 1'b1;
    s0_valid_i = 1'b1;
    s1_valid_i = 1'b1;
    s0_data_i  = $urandom();
    s1_data_i  = $urandom();
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({sck_o, ws_o, busy_o, s0_ready_o, s1_ready_o, underrun_o, ldata_o, rdata_o} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs c=%0d got sck/ws/busy/r0/r1/ur=%b%b%b%b%b%b l=%h r=%h, want all zero",
                 c, sck_o, ws_o, busy_o, s0_ready_o, s1_ready_o, underrun_o, ldata_o, rdata_o);
      end
      tick();
    end
    rst  = 1'b0;
    en_i = 1'b0;
    tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_idle got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_sck_ws_timing();
    int   rises;
    int   ws_toggles;
    logic prev_sck;
    logic prev_ws;
    do_reset();
    start_run();
    rises      = 0;
    ws_toggles = 0;
    prev_sck   = 1'b0;
    prev_ws    = 1'b0;
    for (int k = 0; k < 530; k++) begin
      #1;
      n_cmp++;
      if ({sck_o, ws_o, busy_o, underrun_o} !== {m_sck(k), m_ws(k), 1'b1, m_fetch(k)}) begin
        n_bad++;
        $display("FAIL sck_ws_timing k=%0d got sck/ws/busy/ur=%b%b%b%b want %b%b1%b",
                 k, sck_o, ws_o, busy_o, underrun_o, m_sck(k), m_ws(k), m_fetch(k));
      end
      if (k < 256 && sck_o && !prev_sck) rises++;
      if (ws_o !== prev_ws) ws_toggles++;
      prev_sck = sck_o;
      prev_ws  = ws_o;
      tick();
    end
    n_cmp++;
    if (rises != 32) begin
      n_bad++;
      $display("FAIL sck_periods_per_frame got %0d want 32", rises);
    end
    n_cmp++;
    if (ws_toggles != 4) begin
      n_bad++;
      $display("FAIL ws_toggles_530clk got %0d want 4", ws_toggles);
    end
  endtask

  task automatic test_priority();
    int pulses;
    do_reset();
    s0_valid_i = 1'b1;
    s1_valid_i = 1'b1;
    s0_data_i  = 32'hAAAA_5555;
    s1_data_i  = $urandom();
    start_run();
    pulses = 0;
    for (int k = 0; k < 270; k++) begin
      #1;
      n_cmp++;
      if ({s0_ready_o, s1_ready_o, underrun_o} !== {m_fetch(k), 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL priority_ready k=%0d got r0/r1/ur=%b%b%b want %b00",
                 k, s0_ready_o, s1_ready_o, underrun_o, m_fetch(k));
      end
      if (s0_ready_o) pulses++;
      if (k == 128) begin
        n_cmp++;
        if (ldata_o !== 16'hAAAA) begin
          n_bad++;
          $display("FAIL priority_ldata got %h want aaaa", ldata_o);
        end
      end
      if (k == 256) begin
        n_cmp++;
        if (rdata_o !== 16'h5555) begin
          n_bad++;
          $display("FAIL priority_rdata got %h want 5555", rdata_o);
        end
      end
      tick();
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL priority_pulse_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_fallback_underrun();
    int urs;
    do_reset();
    s0_valid_i = 1'b0;
    s1_valid_i = 1'b1;
    s0_data_i  = $urandom();
    s1_data_i  = 32'h1234_5678;
    start_run();
    urs = 0;
    for (int k = 0; k < 520; k++) begin
      if (k == 128) s1_valid_i = 1'b0;
      #1;
      n_cmp++;
      if ({s0_ready_o, s1_ready_o, underrun_o} !==
          {1'b0, m_fetch(k) && (k < 128), m_fetch(k) && (k >= 128)}) begin
        n_bad++;
        $display("FAIL fallback_strobes k=%0d got r0/r1/ur=%b%b%b want 0%b%b", k,
                 s0_ready_o, s1_ready_o, underrun_o, m_fetch(k) && (k < 128), m_fetch(k) && (k >= 128));
      end
      if (underrun_o) urs++;
      if (k == 128 || k == 384) begin
        n_cmp++;
        if (ldata_o !== ((k == 128) ? 16'h1234 : 16'h0000)) begin
          n_bad++;
          $display("FAIL fallback_ldata k=%0d got %h want %h", k, ldata_o, (k == 128) ? 16'h1234 : 16'h0000);
        end
      end
      if (k == 256 || k == 512) begin
        n_cmp++;
        if (rdata_o !== ((k == 256) ? 16'h5678 : 16'h0000)) begin
          n_bad++;
          $display("FAIL fallback_rdata k=%0d got %h want %h", k, rdata_o, (k == 256) ? 16'h5678 : 16'h0000);
        end
      end
      tick();
    end
    n_cmp++;
    if (urs != 1) begin
      n_bad++;
      $display("FAIL underrun_pulse_count got %0d want 1", urs);
    end
  endtask

  // en_i drops in the cycle where the second left half is on bit 3 (fall 35).
  task automatic test_drain();
    logic [2*DW-1:0] pair;
    do_reset();
    pair       = $urandom();
    s0_valid_i = 1'b1;
    s0_data_i  = pair;
    start_run();
    for (int k = 0; k < 600; k++) begin
      if (k == 282) en_i = 1'b0;
      #1;
      n_cmp++;
      if (k < 512) begin
        if ({sck_o, ws_o, busy_o, s0_ready_o} !== {m_sck(k), m_ws(k), 1'b1, m_fetch(k)}) begin
          n_bad++;
          $display("FAIL drain_active k=%0d got sck/ws/busy/r0=%b%b%b%b want %b%b1%b",
                   k, sck_o, ws_o, busy_o, s0_ready_o, m_sck(k), m_ws(k), m_fetch(k));
        end
      end else begin
        if ({sck_o, ws_o, busy_o, s0_ready_o} !== 4'b0000) begin
          n_bad++;
          $display("FAIL drain_idle k=%0d got sck/ws/busy/r0=%b%b%b%b want 0000",
                   k, sck_o, ws_o, busy_o, s0_ready_o);
        end
      end
      if (k == 599) begin
        n_cmp++;
        if ({ldata_o, rdata_o} !== pair) begin
          n_bad++;
          $display("FAIL drain_hold got %h%h want %h", ldata_o, rdata_o, pair);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    s0_valid_i = 1'b1;
    s0_data_i  = {16'($urandom_range(1, 16'hFFFF)), 16'h5555};
    start_run();
    repeat (300) tick();
    #1;
    n_cmp++;
    if (rdata_o !== 16'h5555) begin
      n_bad++;
      $display("FAIL rst_mid_precond got rdata=%h want 5555", rdata_o);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sck_o, ws_o, busy_o, s0_ready_o, s1_ready_o, underrun_o, ldata_o, rdata_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_immediate got sck/ws/busy/r0/r1/ur=%b%b%b%b%b%b l=%h r=%h want all zero",
               sck_o, ws_o, busy_o, s0_ready_o, s1_ready_o, underrun_o, ldata_o, rdata_o);
    end
    tick();
    n_cmp++;
    if ({sck_o, ws_o, busy_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_mid_held got sck/ws/busy=%b%b%b want 000", sck_o, ws_o, busy_o);
    end
    rst  = 1'b0;
    en_i = 1'b0;
    tick();
  endtask

  // Random sources, a short en_i glitch (must not disturb the frame) and a random stop.
  // The session ends after a frame-end cycle in which en_i was low, having also been
  // low in the cycle before it.
  task automatic test_random();
    int   kd;
    int   idle_at;
    int   m_urun;
    logic en_prev;
    logic busy_exp;
    logic fe;
    logic fs;
    logic e_r0;
    logic e_r1;
    logic e_ur;
    do_reset();
    kd      = 1030 + $urandom_range(0, 399);
    idle_at = -1;
    m_urun  = 0;
    en_prev = 1'b1;
    start_run();
    for (int k = 0; k < kd + 700; k++) begin
      en_i       = (idle_at < 0) && !((k >= 300 && k < 310) || k >= kd);
      s0_valid_i = ($urandom_range(0, 2) == 0);
      s1_valid_i = $urandom_range(0, 1) == 1;
      s0_data_i  = $urandom();
      s1_data_i  = $urandom();
      #1;
      busy_exp = (idle_at < 0) || (k < idle_at);
      fs   = busy_exp && m_fetch(k);
      fe   = busy_exp && m_fend(k);
      e_r0 = fs && s0_valid_i;
      e_r1 = fs && !s0_valid_i && s1_valid_i;
      e_ur = fs && !s0_valid_i && !s1_valid_i;
      n_cmp++;
      if ({sck_o, ws_o, busy_o, s0_ready_o, s1_ready_o, underrun_o, ldata_o, rdata_o} !==
          {busy_exp && m_sck(k), busy_exp && m_ws(k), busy_exp, e_r0, e_r1, e_ur, exp_l, exp_r}) begin
        n_bad++;
        $display("FAIL random k=%0d got sck/ws/busy/r0/r1/ur=%b%b%b%b%b%b l=%h r=%h want %b%b%b%b%b%b l=%h r=%h",
                 k, sck_o, ws_o, busy_o, s0_ready_o, s1_ready_o, underrun_o, ldata_o, rdata_o,
                 busy_exp && m_sck(k), busy_exp && m_ws(k), busy_exp, e_r0, e_r1, e_ur, exp_l, exp_r);
      end
      if (fs) begin
        if (e_r0) {exp_l, exp_pend} = s0_data_i;
        else if (e_r1) {exp_l, exp_pend} = s1_data_i;
        else begin
          exp_l    = '0;
          exp_pend = '0;
          m_urun++;
        end
      end
      if (fe) begin
        exp_r = exp_pend;
        if (!en_i && !en_prev) idle_at = k + 1;
      end
      en_prev = en_i;
      tick();
    end
    n_cmp++;
    if (idle_at < 0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL random_stop_bound idle_at=%0d busy=%b want stop within budget and busy 0", idle_at, busy_o);
    end
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
    n_cmp++;
    if (underrun_cnt_o !== 16'(m_urun)) begin
      n_bad++;
      $display("FAIL underrun_cnt got %0d want %0d", underrun_cnt_o, m_urun);
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    en_i       = 1'b0;
    s0_valid_i = 1'b0;
    s1_valid_i = 1'b0;
    s0_data_i  = '0;
    s1_data_i  = '0;
    test_reset();
    test_sck_ws_timing();
    test_priority();
    test_fallback_underrun();
    test_drain();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
